// File: rtl/fx_10bit_band_combiner.sv
`default_nettype none
// ============================================================================
//  Module   : fx_10bit_band_combiner
//  Brief    : Recombines four sign-magnitude Q0.9 band samples, each scaled
//             by a programmable gain, through one time-multiplexed MAC.
//             The 12-bit sum is saturated back to 10-bit sign-magnitude.
//  Revision : 1.0  initial release
// ============================================================================
module fx_10bit_band_combiner #(
    parameter int         NBANDS   = 4,
    parameter logic [9:0] GAIN_RST = 10'b0111111111
) (
    input  logic                   clk_slow,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [10*NBANDS-1:0]   band_in,
    input  logic                   gain_we,
    input  logic [1:0]             gain_addr,
    input  logic [9:0]             gain_data,
    output logic                   out_valid,
    output logic [9:0]             out_data,
    output logic                   out_sat
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] C_LAST_BAND = 2'(NBANDS - 1);

    state_t             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic signed [11:0] acc_q, acc_d;
    logic [9:0]         band_q [NBANDS];
    logic [9:0]         band_d [NBANDS];
    logic [9:0]         gain_q [NBANDS];
    logic [9:0]         gain_d [NBANDS];
    logic [9:0]         out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_sat_q, out_sat_d;

    logic [9:0]         w_band_in [NBANDS];

    // Split the flat input bus into per-band samples
    for (genvar k = 0; k < NBANDS; k++) begin : g_unpack
        assign w_band_in[k] = band_in[10*k +: 10];
    end

    // Product of the currently selected band and its gain.
    // A zero-magnitude product is forced to +0 so negative zero never enters the sum.
    logic [9:0]         w_band_sel;
    logic [9:0]         w_gain_sel;
    logic [17:0]        w_prod_full;
    logic [8:0]         w_prod_mag;
    logic signed [11:0] w_prod;

    always_comb begin
        w_band_sel  = band_q[cnt_q];
        w_gain_sel  = gain_q[cnt_q];
        w_prod_full = w_band_sel[8:0] * w_gain_sel[8:0];
        w_prod_mag  = w_prod_full[17:9];
        if (w_prod_mag == 9'd0) begin
            w_prod = 12'sd0;
        end else if (w_band_sel[9] ^ w_gain_sel[9]) begin
            w_prod = -$signed({3'b000, w_prod_mag});
        end else begin
            w_prod = $signed({3'b000, w_prod_mag});
        end
    end

    // Saturating conversion of the accumulator back to sign-magnitude
    logic [11:0] w_acc_abs;
    logic        w_acc_sat;
    logic [9:0]  w_acc_sm;

    always_comb begin
        w_acc_abs = acc_q[11] ? 12'(-acc_q) : 12'(acc_q);
        w_acc_sat = (w_acc_abs > 12'd511);
        if (w_acc_sat) begin
            w_acc_sm = {acc_q[11], 9'h1FF};
        end else if (acc_q == 12'sd0) begin
            w_acc_sm = 10'd0;
        end else begin
            w_acc_sm = {acc_q[11], w_acc_abs[8:0]};
        end
    end

    // Next-state, datapath and gain-register update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        band_d      = band_q;
        gain_d      = gain_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_valid_d = 1'b0;

        // The MAC reads gain_q, so a same-edge write is seen only from the next edge on
        if (gain_we) begin
            gain_d[gain_addr] = gain_data;
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    band_d  = w_band_in;
                    acc_d   = 12'sd0;
                    cnt_d   = 2'd0;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                acc_d = acc_q + w_prod;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == C_LAST_BAND) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_data_d  = w_acc_sm;
                out_sat_d   = w_acc_sat;
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_slow) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            acc_q       <= 12'sd0;
            out_data_q  <= 10'd0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
            for (int k = 0; k < NBANDS; k++) begin
                gain_q[k] <= GAIN_RST;
                band_q[k] <= 10'd0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sat_q   <= out_sat_d;
            gain_q      <= gain_d;
            band_q      <= band_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_fx_10bit_band_combiner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fx_10bit_band_combiner
//  Brief    : Self-checking bench for fx_10bit_band_combiner with an
//             arithmetic reference model of the weighted band sum.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fx_10bit_band_combiner;

    logic        clk_slow = 1'b0;
    logic        rst      = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [39:0] band_in  = 40'd0;
    logic        gain_we  = 1'b0;
    logic [1:0]  gain_addr = 2'd0;
    logic [9:0]  gain_data = 10'd0;
    logic        out_valid;
    logic [9:0]  out_data;
    logic        out_sat;

    int n_checks = 0;
    int n_fail   = 0;

    // Gains as the DUT should currently hold them
    logic [9:0] gm [4];

    fx_10bit_band_combiner #(
        .NBANDS   (4),
        .GAIN_RST (10'b0111111111)
    ) u_dut (
        .clk_slow  (clk_slow),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .band_in   (band_in),
        .gain_we   (gain_we),
        .gain_addr (gain_addr),
        .gain_data (gain_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk_slow = ~clk_slow;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_slow);
        #1;
    endtask

    function automatic logic [39:0] rnd40();
        return {8'($urandom), 32'($urandom)};
    endfunction

    // Signed product value of two sign-magnitude Q0.9 numbers (truncated magnitude)
    function automatic int mulq(input logic [9:0] a, input logic [9:0] b);
        int m;
        m = (int'(a[8:0]) * int'(b[8:0])) / 512;
        return (a[9] ^ b[9]) ? -m : m;
    endfunction

    // Expected {out_sat, out_data} for a band set under gains gm
    function automatic logic [10:0] model(input logic [39:0] bands);
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            s += mulq(bands[10*k +: 10], gm[k]);
        end
        if (s > 511)  return {1'b1, 10'h1FF};
        if (s < -511) return {1'b1, 10'h3FF};
        if (s < 0)    return {1'b0, 1'b1, 9'(-s)};
        return {1'b0, 1'b0, 9'(s)};
    endfunction

    task automatic write_gain(input logic [1:0] a, input logic [9:0] d);
        gain_we   = 1'b1;
        gain_addr = a;
        gain_data = d;
        tick();
        gain_we   = 1'b0;
        gm[a]     = d;
    endtask

    task automatic set_all_gains(input logic [9:0] d);
        for (int k = 0; k < 4; k++) write_gain(2'(k), d);
    endtask

    // One full transaction from IDLE, checking latency, output and handshake
    task automatic run_sample(input logic [39:0] b, input string tag);
        logic [10:0] exp;
        int w;
        int lat;
        exp      = model(b);
        band_in  = b;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        band_in  = rnd40();
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd5);
        check({tag, "_data"}, 32'(out_data), 32'(exp[9:0]));
        check({tag, "_sat"}, 32'(out_sat), 32'(exp[10]));
        check({tag, "_ready_at_valid"}, 32'(in_ready), 32'd1);
        tick();
        check({tag, "_valid_pulse"}, 32'(out_valid), 32'd0);
        check({tag, "_data_hold"}, 32'(out_data), 32'(exp[9:0]));
    endtask

    initial begin
        logic [39:0] acc_b;
        logic [9:0]  newg;
        logic [10:0] exp;
        int          seen;

        for (int k = 0; k < 4; k++) gm[k] = 10'h1FF;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_out_data", 32'(out_data), 32'h000);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Default gains, positive saturation
        run_sample({4{10'h100}}, "dflt_possat");

        // Gain write then MAC
        set_all_gains(10'h100);
        run_sample({4{10'h040}}, "gain_mac");

        // Sign cancellation and negative zero
        set_all_gains(10'h1FF);
        run_sample({10'h000, 10'h000, 10'h300, 10'h100}, "cancel");
        run_sample({10'h000, 10'h000, 10'h200, 10'h200}, "negzero");

        // Negative saturation then zero
        run_sample({4{10'h3FF}}, "negsat");
        run_sample(40'd0, "zero_after_sat");

        // Randomized sets with random gain updates in IDLE
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1) write_gain(2'($urandom_range(0, 3)), 10'($urandom));
            if ($urandom_range(0, 2) == 0) write_gain(2'($urandom_range(0, 3)), 10'($urandom));
            run_sample(rnd40(), "rand");
        end

        // Continuous in_valid, changing band_in, mid-sample gain write to band 3
        in_valid = 1'b1;
        band_in  = rnd40();
        for (int r = 0; r < 3; r++) begin
            check("proto_accept_ready", 32'(in_ready), 32'd1);
            acc_b = band_in;
            tick();
            newg = 10'($urandom);
            for (int c = 1; c <= 5; c++) begin
                check("proto_busy", 32'(in_ready), 32'd0);
                band_in = rnd40();
                if (c == 2) begin
                    gain_we   = 1'b1;
                    gain_addr = 2'd3;
                    gain_data = newg;
                end else begin
                    gain_we = 1'b0;
                end
                tick();
            end
            gain_we = 1'b0;
            gm[3]   = newg;
            exp     = model(acc_b);
            check("proto_valid", 32'(out_valid), 32'd1);
            check("proto_data", 32'(out_data), 32'(exp[9:0]));
            check("proto_sat", 32'(out_sat), 32'(exp[10]));
        end
        in_valid = 1'b0;
        tick();

        // Reset in the middle of accumulation
        set_all_gains(10'h155);
        band_in  = {4{10'h0AA}};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) gm[k] = 10'h1FF;
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_data", 32'(out_data), 32'h000);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("midrst_no_pulse", 32'(seen), 32'd0);
        run_sample({10'h0C3, 10'h2F0, 10'h17E, 10'h1FF}, "after_rst");
        run_sample(rnd40(), "after_rst_rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fx_10bit_band_combiner.md
Name: fx_10bit_band_combiner

Overview:
- Synthesis-side counterpart to the 4-band 10-bit fixed-point FIR analysis bank.
- Takes one sample from each of the four band filter outputs and applies a programmable per-band gain to each.
- Sums the four weighted bands with a single time-multiplexed multiply-accumulate, saturates, and emits one recombined 10-bit sample.
- Sits after the four band FIR instances on the clk_slow domain.

Parameters:
- NBANDS, 4, number of bands combined; fixes the MAC count and band-index width (2 bits).
- GAIN_RST, 10'b0111111111, reset value of every gain register (+511/512).

Ports:
- clk_slow  in  1  system sample clock; all state on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  band samples present on band_in.
- in_ready  out  1  block can accept a sample set.
- band_in  in  40  four band samples; band k = band_in[10k+9:10k].
- gain_we  in  1  gain register write strobe.
- gain_addr  in  2  gain register index (band).
- gain_data  in  10  gain value, sign-magnitude.
- out_valid  out  1  one-cycle pulse: out_data updated.
- out_data  out  10  recombined sample, sign-magnitude.
- out_sat  out  1  last output was saturated; updates with out_valid.

Behaviour:
- Number format for band_in, gain_data and out_data:
  - 10-bit sign-magnitude Q0.9: bit 9 = sign (1 = negative), bits 8:0 = magnitude/512.
  - 10'b1000000000 (negative zero) is accepted as an input and treated as 0.
- Product rule, identical to the team's fixed-point multiplier:
  - magnitude = (mag_a * mag_b) >> 9, truncated.
  - sign = sign_a XOR sign_b.
  - A product with zero magnitude is +0.
- Accumulator: 12-bit two's complement; no intermediate overflow is possible (|sum| <= 2040).
- FSM states: IDLE, ACC, DONE. Band counter cnt is 2 bits.
  - IDLE: in_ready = 1. When in_valid=1 at an edge, register all of band_in, clear acc, set cnt=0, go to ACC. in_valid=0 stays in IDLE.
  - ACC: in_ready = 0. Each edge adds product(band[cnt], gain[cnt]) to acc and increments cnt. The edge with cnt==3 goes to DONE.
  - DONE: in_ready = 0. Next edge:
    - out_data <= saturate(acc); out_sat <= (|acc| > 511); out_valid <= 1.
    - Go to IDLE.
- Output conversion:
  - acc > 511 -> 10'b0111111111.
  - acc < -511 -> 10'b1111111111.
  - acc == 0 -> 10'b0000000000; negative zero is never emitted.
  - Otherwise sign-magnitude of acc.
- Timing:
  - Latency: accept edge E0, accumulate edges E1..E4, output edge E5.
  - out_valid is high for exactly the cycle after E5; in_ready is high in that same cycle.
  - Next accept is E6 at the earliest. Sustained throughput is 1 sample per 6 clk_slow cycles.
- out_data and out_sat hold their value between out_valid pulses. out_valid is otherwise 0.
- in_valid while in_ready=0 is ignored and not queued. The source must hold in_valid until accepted.
- Gain writes are allowed in any state.
  - A write at edge E updates gain[gain_addr] at E.
  - A MAC at the same edge uses the pre-write value.
  - Writes in IDLE affect the next sample set.
- Reset:
  - On rst=1 at an edge: state=IDLE, cnt=0, acc=0, out_data=0, out_valid=0, out_sat=0, all gains=GAIN_RST.
  - in_ready is 1 in the cycle after the reset edge.
  - rst overrides in_valid and gain_we at the same edge.
  - Reset during ACC or DONE aborts the sample; no out_valid pulse follows.

Test Plan:
- Reset: hold rst 2 cycles -> out_data=0x000, out_valid=0, out_sat=0, in_ready=1. Then with all bands=0x100 and default gains -> out_data=0x1FF, out_sat=1 (4*255=1020 saturates).
- Gain write and MAC: write gains all 0x100; bands all 0x040 -> each product 32, out_data=0x080, out_sat=0. out_valid pulses exactly 5 edges after the accept edge.
- Sign cancellation: gains 0x1FF; band0=0x100, band1=0x300, bands2/3=0x000 -> products +255, -255; out_data=0x000 (never 0x200). Repeat with band0=0x200 (negative zero) and band1=0x200 -> out_data=0x000.
- Negative saturation: gains 0x1FF; all bands=0x3FF -> each product -510, acc=-2040; out_data=0x3FF, out_sat=1. A following sample with all bands 0 -> out_data=0x000, out_sat=0.
- Protocol: hold in_valid=1 continuously with a changing band_in:
  - Accepts occur every 6 cycles.
  - in_ready=0 during ACC/DONE; band_in changes during those cycles do not affect the result.
  - A gain write to band 3 during the cnt==1 ACC edge is used by the same sample.
- Reset mid-operation: assert rst for 1 cycle at the second ACC edge -> no out_valid pulse for that sample; gains return to 0x1FF; in_ready=1 the next cycle; a new sample processes correctly.
